// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner.
// Each channel synchronises a raw asynchronous button and debounces it with a
// 4-state FSM. It holds the stable level and emits one-cycle event pulses. The
// pulse events are press, release, both edges, or press with auto-repeat.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   en         event enable; 0 suppresses pulses and clears repeat timers only
//   mode       00 press, 01 release, 10 both edges, 11 press + auto-repeat
//   button     raw asynchronous button inputs, active-high
//   level      debounced button state, registered
//   pulse      one-cycle event per channel, registered
//   any_pulse  OR of pulse
module button_conditioner #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_RATE     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pulse,
  output logic            any_pulse
);

  if (N_CH < 1) begin : g_bad_n_ch
    $error("N_CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 2) begin : g_bad_delay
    $error("REPEAT_DELAY must be >= 2");
  end
  if (REPEAT_RATE < 2) begin : g_bad_rate
    $error("REPEAT_RATE must be >= 2");
  end

  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TmrW   = $clog2(RepMax + 1);

  // The count starts at 1 on the first differing sample, so the level flips
  // when the stored count equals DEBOUNCE_CYCLES-1 and s still disagrees.
  localparam logic [CntW-1:0] DbLast    = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmrW-1:0] TmrDelay  = TmrW'(REPEAT_DELAY);
  localparam logic [TmrW-1:0] TmrRate   = TmrW'(REPEAT_RATE);
  localparam logic [TmrW-1:0] TmrOne    = TmrW'(1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [1:0] {
    StReleased   = 2'd0,
    StPressCnt   = 2'd1,
    StPressed    = 2'd2,
    StReleaseCnt = 2'd3
  } state_e;

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] s;

  state_e          state_q [N_CH];
  state_e          state_d [N_CH];
  logic [CntW-1:0] cnt_q   [N_CH];
  logic [CntW-1:0] cnt_d   [N_CH];
  logic [TmrW-1:0] timer_q [N_CH];
  logic [TmrW-1:0] timer_d [N_CH];
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] pulse_q, pulse_d;
  logic [N_CH-1:0] rise, fall, rep, run;

  // Synchroniser chain; the last stage is the FSM input.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= button;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= StReleased;
        cnt_q[i]   <= '0;
        timer_q[i] <= '0;
      end
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        timer_q[i] <= timer_d[i];
      end
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    rise    = '0;
    fall    = '0;
    rep     = '0;
    run     = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      timer_d[i] = '0;

      // Debounce FSM.
      unique case (state_q[i])
        StReleased: begin
          if (s[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d[i] = StPressed;
              level_d[i] = 1'b1;
            end else begin
              state_d[i] = StPressCnt;
              cnt_d[i]   = CntOne;
            end
          end
        end
        StPressCnt: begin
          if (!s[i]) begin
            state_d[i] = StReleased;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DbLast) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StPressed: begin
          if (!s[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d[i] = StReleased;
              level_d[i] = 1'b0;
            end else begin
              state_d[i] = StReleaseCnt;
              cnt_d[i]   = CntOne;
            end
          end
        end
        StReleaseCnt: begin
          if (s[i]) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DbLast) begin
            state_d[i] = StReleased;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          state_d[i] = StReleased;
          cnt_d[i]   = '0;
          level_d[i] = 1'b0;
        end
      endcase

      rise[i] = level_d[i] & ~level_q[i];
      fall[i] = ~level_d[i] & level_q[i];

      // A non-zero timer means a press in repeat mode armed it. The timer
      // counts down to 1 and then reloads. Any break in repeat conditions
      // zeroes it, so it cannot restart until a fresh press.
      run[i] = (state_q[i] == StPressed || state_q[i] == StReleaseCnt) &&
               (mode == 2'b11) && en && (timer_q[i] != '0);
      if (run[i]) begin
        if (timer_q[i] == TmrOne) begin
          rep[i]     = level_d[i];  // drop a repeat that lands on the release edge
          timer_d[i] = TmrRate;
        end else begin
          timer_d[i] = timer_q[i] - TmrOne;
        end
      end
      if (fall[i]) timer_d[i] = '0;
      if (rise[i] && en && mode == 2'b11) timer_d[i] = TmrDelay;

      if (en) begin
        unique case (mode)
          2'b00:   pulse_d[i] = rise[i];
          2'b01:   pulse_d[i] = fall[i];
          2'b10:   pulse_d[i] = rise[i] | fall[i];
          default: pulse_d[i] = rise[i] | rep[i];
        endcase
      end
    end
  end

  assign level     = level_q;
  assign pulse     = pulse_q;
  assign any_pulse = |pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner. A behavioural model derives the
// expected level and pulse from the input history. Directed scenarios run
// first, then randomised button, mode, enable and reset activity.
module tb_button_conditioner;

  localparam int N_CH = 4;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int RD   = 16;
  localparam int RR   = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b1;
  logic [1:0]      mode = 2'b00;
  logic [N_CH-1:0] button = '0;
  logic [N_CH-1:0] level, pulse;
  logic            any_pulse;

  button_conditioner #(
    .N_CH            (N_CH),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .button    (button),
    .level     (level),
    .pulse     (pulse),
    .any_pulse (any_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [N_CH-1:0] hist [SYNC];
  logic [N_CH-1:0] m_lvl   = '0;
  logic [N_CH-1:0] m_pulse = '0;
  int              m_run   [N_CH];
  bit              m_armed [N_CH];
  int              m_age   [N_CH];

  // Stimulus state.
  logic            cur_en   = 1'b1;
  logic [1:0]      cur_mode = 2'b00;
  int              pcnt [N_CH];
  logic [N_CH-1:0] last_pv = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < SYNC; k++) hist[k] = '0;
    m_lvl   = '0;
    m_pulse = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_run[c]   = 0;
      m_armed[c] = 0;
      m_age[c]   = 0;
    end
  endtask

  // Applies one clock edge of the specified behaviour using the inputs
  // present at that edge.
  task automatic model_edge();
    logic [N_CH-1:0] s;
    logic nl, r, f, rp;
    if (reset) begin
      model_reset();
      return;
    end
    s = hist[SYNC-1];
    for (int k = SYNC - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = button;
    for (int c = 0; c < N_CH; c++) begin
      nl = m_lvl[c];
      if (s[c] != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] >= DB) begin
          nl       = s[c];
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      r  = nl & ~m_lvl[c];
      f  = ~nl & m_lvl[c];
      rp = 1'b0;
      if (m_armed[c] && m_lvl[c] && mode == 2'b11 && en) begin
        m_age[c]++;
        if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RR == 0)) rp = nl;
      end else begin
        m_armed[c] = 0;
      end
      if (f) m_armed[c] = 0;
      if (r && en && mode == 2'b11) begin
        m_armed[c] = 1;
        m_age[c]   = 0;
      end
      case (mode)
        2'b00:   m_pulse[c] = en & r;
        2'b01:   m_pulse[c] = en & f;
        2'b10:   m_pulse[c] = en & (r | f);
        default: m_pulse[c] = en & (r | rp);
      endcase
      m_lvl[c] = nl;
    end
  endtask

  task automatic step(input logic rst, input logic [N_CH-1:0] b);
    reset  = rst;
    en     = cur_en;
    mode   = cur_mode;
    button = b;
    @(posedge clk);
    model_edge();
    #1;
    check("level", level, m_lvl);
    check("pulse", pulse, m_pulse);
    check("any_pulse", any_pulse, |m_pulse);
    for (int c = 0; c < N_CH; c++) pcnt[c] += pulse[c];
    if (pulse != '0) last_pv = pulse;
  endtask

  task automatic hold(input int n, input logic [N_CH-1:0] b);
    for (int i = 0; i < n; i++) step(1'b0, b);
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N_CH; c++) pcnt[c] = 0;
    last_pv = '0;
  endtask

  initial begin
    logic [N_CH-1:0] b;
    int              prob;
    model_reset();
    clear_counts();

    // 1: button held through reset.
    cur_mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'hF);
      check("t1 reset level", level, 4'h0);
      check("t1 reset pulse", pulse, 4'h0);
    end
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 4'hF);
      if (i == 5) check("t1 level before edge6", level, 4'h0);
      if (i == 6) begin
        check("t1 level at edge6", level, 4'hF);
        check("t1 pulse at edge6", pulse, 4'hF);
      end
      if (i == 7) check("t1 pulse after edge6", pulse, 4'h0);
    end
    hold(12, 4'h0);

    // 2: release mode.
    cur_mode = 2'b01;
    clear_counts();
    hold(10, 4'h1);
    check("t2 no press pulse", pcnt[0], 0);
    check("t2 level held", level[0], 1'b1);
    hold(10, 4'h0);
    check("t2 release pulse", pcnt[0], 1);
    check("t2 level released", level[0], 1'b0);

    // 3: glitch rejection at the debounce boundary.
    cur_mode = 2'b00;
    clear_counts();
    hold(3, 4'h2);
    hold(10, 4'h0);
    check("t3 3-cycle glitch", pcnt[1], 0);
    hold(4, 4'h2);
    hold(10, 4'h0);
    check("t3 4-cycle press", pcnt[1], 1);

    // 4: both edges.
    cur_mode = 2'b10;
    clear_counts();
    hold(8, 4'h4);
    hold(10, 4'h0);
    check("t4 both edges", pcnt[2], 2);

    // 5: auto-repeat over a 40-cycle hold.
    cur_mode = 2'b11;
    clear_counts();
    hold(40, 4'h8);
    hold(10, 4'h0);
    check("t5 repeat count", pcnt[3], 7);

    // 6: enable gating, then simultaneous presses.
    cur_mode = 2'b00;
    cur_en   = 1'b0;
    clear_counts();
    hold(8, 4'h9);
    check("t6 level with en=0", level, 4'h9);
    check("t6 pulses with en=0", pcnt[0] + pcnt[3], 0);
    hold(10, 4'h0);
    cur_en = 1'b1;
    clear_counts();
    hold(8, 4'h9);
    check("t6 joint pulse", last_pv, 4'b1001);
    check("t6 pulse count", pcnt[0] + pcnt[3], 2);
    hold(10, 4'h0);

    // Randomised activity: alternate bouncy and long-hold segments.
    b = '0;
    for (int seg = 0; seg < 6; seg++) begin
      prob = (seg % 2 == 0) ? 4 : 30;
      for (int i = 0; i < 300; i++) begin
        for (int c = 0; c < N_CH; c++)
          if ($urandom_range(prob - 1) == 0) b[c] = ~b[c];
        if ($urandom_range(49) == 0) cur_mode = 2'($urandom_range(3));
        if ($urandom_range(99) == 0) cur_en = 1'b0;
        else if (!cur_en && $urandom_range(19) == 0) cur_en = 1'b1;
        step($urandom_range(399) == 0, b);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
